vb_loader: RTL and testbench

- Upload controller for the triangle vertex buffer read by the scan stage.
- Accepts a 27-bit word stream and packs 8 words into one 216-bit triangle record (a, b, c, n).
- Drives the buffer write port (wen/wdata/waddr) on clk.
- Publishes the new triangle count on wsize only after the scan stage reports a frame boundary, so a scene commit never lands mid-frame.

---
 rtl/vb_loader.sv | 203 ++++++++++++++++++++
 tb/tb_vb_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vb_loader.sv
// vb_loader - upload controller for the triangle vertex buffer.
//
// Packs a stream of WORD_W-bit words, WORDS_PER_TRI at a time, into one
// triangle record (first word most significant) and writes it into the vertex
// buffer at consecutive addresses. The scene size seen by the scan stage
// (wsize) only changes right after scan reports a frame boundary, so a scene
// commit never lands in the middle of a frame.
//
// Optional build macro: VB_LOADER_STATS_EN adds scene_count / drop_count.
//
// Ports:
//   clk           system clock, also the vertex buffer write clock
//   rst           synchronous, active-high reset
//   in_valid      stream word valid
//   in_ready      stream word accepted when in_valid & in_ready
//   in_data       stream word
//   in_last       final word of a scene
//   frame_done    one-cycle frame boundary pulse from scan
//   wen           buffer write enable
//   wdata         assembled triangle record
//   waddr         buffer write address
//   wsize         committed triangle count for scan
//   commit_pulse  one cycle, marks a scene commit (wsize update point)
//   overflow      sticky: a triangle was dropped because the scene was full
//   framing_err   sticky: in_last arrived mid-record
//   scene_count   (VB_LOADER_STATS_EN) commits seen, wrapping
//   drop_count    (VB_LOADER_STATS_EN) suppressed writes, saturating
module vb_loader #(
  parameter int WORD_W        = 27,
  parameter int WORDS_PER_TRI = 8,
  parameter int ADDR_W        = 12,
  parameter int MAX_TRIS      = 4095,
  parameter int RESET_SIZE    = 36
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WORD_W-1:0]               in_data,
  input  logic                            in_last,
  input  logic                            frame_done,
  output logic                            wen,
  output logic [WORD_W*WORDS_PER_TRI-1:0] wdata,
  output logic [ADDR_W-1:0]               waddr,
  output logic [ADDR_W-1:0]               wsize,
  output logic                            commit_pulse,
  output logic                            overflow,
  output logic                            framing_err
`ifdef VB_LOADER_STATS_EN
  ,
  output logic [15:0]                     scene_count,
  output logic [15:0]                     drop_count
`endif
);

  localparam int REC_W = WORD_W * WORDS_PER_TRI;
  localparam int IDX_W = (WORDS_PER_TRI > 1) ? $clog2(WORDS_PER_TRI) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(WORDS_PER_TRI - 1);
  localparam logic [ADDR_W-1:0] MAX_TRIS_C   = ADDR_W'(MAX_TRIS);
  localparam logic [ADDR_W-1:0] RESET_SIZE_C = ADDR_W'(RESET_SIZE);

  typedef enum logic [1:0] {
    COLLECT    = 2'd0,
    WRITE      = 2'd1,
    WAIT_FRAME = 2'd2,
    COMMIT     = 2'd3
  } state_t;

  state_t                   state_r;
  logic [IDX_W-1:0]         word_idx_r;
  logic [ADDR_W-1:0]        tri_count_r;
  logic                     commit_pend_r;
  // Only the words already received are kept; the newest word joins on the
  // final beat straight into wdata.
  logic [REC_W-WORD_W-1:0]  rec_r;

  logic                     accept_s;
  logic                     last_word_s;
  logic                     has_room_s;
  logic [REC_W-1:0]         rec_next_s;

  assign accept_s    = in_valid & in_ready & (state_r == COLLECT);
  assign last_word_s = (word_idx_r == LAST_IDX);
  assign has_room_s  = (tri_count_r < MAX_TRIS_C);
  // Shifting left puts the first word of the record in the top slot.
  assign rec_next_s  = {rec_r, in_data};

`ifdef VB_LOADER_STATS_EN
  // Scene and drop statistics, both cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scene_count <= 16'd0;
      drop_count  <= 16'd0;
    end else begin
      if ((state_r == WAIT_FRAME) && frame_done) begin
        scene_count <= scene_count + 16'd1;
      end else begin
        scene_count <= scene_count;
      end
      if ((state_r == COLLECT) && accept_s && last_word_s && !has_room_s &&
          (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end else begin
        drop_count <= drop_count;
      end
    end
  end
`endif

  // Loader FSM; all outputs are registered and reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= COLLECT;
      word_idx_r    <= {IDX_W{1'b0}};
      tri_count_r   <= {ADDR_W{1'b0}};
      commit_pend_r <= 1'b0;
      rec_r         <= {(REC_W-WORD_W){1'b0}};
      in_ready      <= 1'b0;
      wen           <= 1'b0;
      wdata         <= {REC_W{1'b0}};
      waddr         <= {ADDR_W{1'b0}};
      wsize         <= RESET_SIZE_C;
      commit_pulse  <= 1'b0;
      overflow      <= 1'b0;
      framing_err   <= 1'b0;
    end else begin
      wen          <= 1'b0;
      commit_pulse <= 1'b0;
      case (state_r)
        COLLECT: begin
          in_ready <= 1'b1;
          if (accept_s) begin
            if (last_word_s) begin
              // Record complete: the write is issued in the WRITE cycle.
              word_idx_r    <= {IDX_W{1'b0}};
              rec_r         <= {(REC_W-WORD_W){1'b0}};
              commit_pend_r <= in_last;
              in_ready      <= 1'b0;
              state_r       <= WRITE;
              if (has_room_s) begin
                wen         <= 1'b1;
                waddr       <= tri_count_r;
                wdata       <= rec_next_s;
                tri_count_r <= tri_count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              end else begin
                overflow <= 1'b1;
              end
            end else if (in_last) begin
              // Scene ended mid-record: drop the partial record, still commit.
              word_idx_r  <= {IDX_W{1'b0}};
              rec_r       <= {(REC_W-WORD_W){1'b0}};
              framing_err <= 1'b1;
              in_ready    <= 1'b0;
              state_r     <= WAIT_FRAME;
            end else begin
              word_idx_r <= word_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
              rec_r      <= rec_next_s[REC_W-WORD_W-1:0];
            end
          end else begin
            state_r <= COLLECT;
          end
        end
        WRITE: begin
          word_idx_r <= {IDX_W{1'b0}};
          if (commit_pend_r) begin
            in_ready <= 1'b0;
            state_r  <= WAIT_FRAME;
          end else begin
            in_ready <= 1'b1;
            state_r  <= COLLECT;
          end
        end
        WAIT_FRAME: begin
          in_ready <= 1'b0;
          if (frame_done) begin
            // An empty scene keeps the previous size so scan never sees zero.
            if (tri_count_r != {ADDR_W{1'b0}}) begin
              wsize <= tri_count_r;
            end else begin
              wsize <= wsize;
            end
            commit_pulse  <= 1'b1;
            tri_count_r   <= {ADDR_W{1'b0}};
            commit_pend_r <= 1'b0;
            state_r       <= COMMIT;
          end else begin
            state_r <= WAIT_FRAME;
          end
        end
        COMMIT: begin
          in_ready <= 1'b1;
          state_r  <= COLLECT;
        end
        default: begin
          word_idx_r <= {IDX_W{1'b0}};
          in_ready   <= 1'b0;
          state_r    <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vb_loader.sv
// Self-checking bench for vb_loader. Two instances share one stimulus stream:
// A uses the default MAX_TRIS, B uses MAX_TRIS=2 to exercise overflow.
module tb_vb_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [26:0]  in_data = 27'd0;
  logic         in_last = 1'b0;
  logic         frame_done = 1'b0;

  logic         a_in_ready, a_wen, a_commit_pulse, a_overflow, a_framing_err;
  logic [215:0] a_wdata;
  logic [11:0]  a_waddr, a_wsize;
  logic         b_in_ready, b_wen, b_commit_pulse, b_overflow, b_framing_err;
  logic [215:0] b_wdata;
  logic [11:0]  b_waddr, b_wsize;

  vb_loader dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .frame_done(frame_done),
    .wen(a_wen), .wdata(a_wdata), .waddr(a_waddr), .wsize(a_wsize),
    .commit_pulse(a_commit_pulse), .overflow(a_overflow), .framing_err(a_framing_err)
  );

  vb_loader #(.MAX_TRIS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .frame_done(frame_done),
    .wen(b_wen), .wdata(b_wdata), .waddr(b_waddr), .wsize(b_wsize),
    .commit_pulse(b_commit_pulse), .overflow(b_overflow), .framing_err(b_framing_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int waits   = 0;

  // Reference model: scene-level bookkeeping per instance.
  int           m_max [2] = '{4095, 2};
  int           m_cnt [2];
  logic [11:0]  m_size[2];
  logic [11:0]  m_addr[2];
  logic [215:0] m_data[2];
  bit           m_ovf [2];
  bit           m_ferr[2];
  bit           m_wen [2];
  bit           m_commit;
  int           m_idx;
  logic [215:0] m_rec;

  task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_size[k] = 12'd36; m_addr[k] = 12'd0; m_data[k] = 216'd0;
      m_ovf[k] = 1'b0; m_ferr[k] = 1'b0; m_wen[k] = 1'b0;
    end
    m_commit = 1'b0; m_idx = 0; m_rec = 216'd0;
  endtask

  // One accepted word: record slot i sits at bits [215-27*i -: 27].
  task automatic model_accept(input logic [26:0] w, input bit last);
    if (m_idx == 7) begin
      m_rec = m_rec | 216'(w);
      for (int k = 0; k < 2; k++) begin
        if (m_cnt[k] < m_max[k]) begin
          m_wen[k] = 1'b1; m_addr[k] = 12'(m_cnt[k]); m_data[k] = m_rec; m_cnt[k]++;
        end else begin
          m_ovf[k] = 1'b1;
        end
      end
      m_idx = 0; m_rec = 216'd0;
    end else if (last) begin
      for (int k = 0; k < 2; k++) m_ferr[k] = 1'b1;
      m_idx = 0; m_rec = 216'd0;
    end else begin
      m_rec = m_rec | (216'(w) << (27 * (7 - m_idx)));
      m_idx++;
    end
  endtask

  task automatic model_commit();
    m_commit = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (m_cnt[k] != 0) m_size[k] = 12'(m_cnt[k]);
      m_cnt[k] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m_wen[0] = 1'b0; m_wen[1] = 1'b0; m_commit = 1'b0;
  endtask

  task automatic check_all();
    chk("A.wen", a_wen, m_wen[0]);           chk("B.wen", b_wen, m_wen[1]);
    chk("A.waddr", a_waddr, m_addr[0]);      chk("B.waddr", b_waddr, m_addr[1]);
    chk("A.wdata", a_wdata, m_data[0]);      chk("B.wdata", b_wdata, m_data[1]);
    chk("A.wsize", a_wsize, m_size[0]);      chk("B.wsize", b_wsize, m_size[1]);
    chk("A.commit", a_commit_pulse, m_commit); chk("B.commit", b_commit_pulse, m_commit);
    chk("A.overflow", a_overflow, m_ovf[0]); chk("B.overflow", b_overflow, m_ovf[1]);
    chk("A.framing_err", a_framing_err, m_ferr[0]);
    chk("B.framing_err", b_framing_err, m_ferr[1]);
  endtask

  task automatic send_word(input logic [26:0] w, input bit last, input bit gap);
    int budget = 0;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin step(); check_all(); end
    end
    in_valid = 1'b1; in_data = w; in_last = last;
    while (!a_in_ready && budget < 40) begin
      step(); check_all(); waits++; budget++;
    end
    chk("A.ready_wait", a_in_ready, 1'b1);
    chk("B.ready_wait", b_in_ready, 1'b1);
    step();
    model_accept(w, last);
    check_all();
    in_last = 1'b0;
  endtask

  task automatic send_scene(input int ntri, input bit gap);
    for (int t = 0; t < ntri; t++)
      for (int i = 0; i < 8; i++)
        send_word(27'($urandom), (t == ntri - 1) && (i == 7), gap);
    in_valid = 1'b0;
  endtask

  task automatic fire_frame();
    in_valid = 1'b0;
    step(); check_all();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    model_commit();
    check_all();
    step(); check_all();
    chk("ready_after_commit", a_in_ready, 1'b1);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (3) step();
    check_all();
    chk("reset_in_ready", a_in_ready, 1'b0);
    rst = 1'b0;
    step(); check_all();
    chk("ready_after_reset", a_in_ready, 1'b1);

    // Single triangle, words 1..8, frame_done in the WRITE cycle is ignored
    for (int i = 1; i <= 8; i++) send_word(27'(i), i == 8, 1'b0);
    in_valid = 1'b0;
    chk("single_waddr", a_waddr, 12'd0);
    frame_done = 1'b1;
    step(); frame_done = 1'b0; check_all();
    for (int c = 0; c < 20; c++) begin
      step(); check_all();
      chk("ready_low_wait", a_in_ready, 1'b0);
    end
    fire_frame();
    chk("single_wsize", a_wsize, 12'd1);

    // Three back-to-back triangles: one ready-low cycle each between records
    waits = 0;
    send_scene(3, 1'b0);
    chk("b2b_ready_gaps", 32'(waits), 32'd2);
    fire_frame();
    chk("b2b_wsize_A", a_wsize, 12'd3);
    chk("b2b_wsize_B_capped", b_wsize, 12'd2);

    // in_last on 5th word: framing error, empty commit keeps wsize
    for (int i = 0; i < 5; i++) send_word(27'($urandom), i == 4, 1'b0);
    in_valid = 1'b0;
    fire_frame();

    // Random scenes with idle gaps on the stream
    for (int s = 0; s < 4; s++) begin
      send_scene($urandom_range(1, 3), 1'b1);
      repeat ($urandom_range(1, 6)) begin step(); check_all(); end
      fire_frame();
    end

    // frame_done in COLLECT is ignored; reset mid-record discards everything
    for (int i = 0; i < 3; i++) send_word(27'($urandom), 1'b0, 1'b0);
    in_valid = 1'b0;
    frame_done = 1'b1;
    step(); frame_done = 1'b0; check_all();
    rst = 1'b1;
    step(); model_reset(); check_all();
    chk("midrec_reset_ready", a_in_ready, 1'b0);
    rst = 1'b0;
    step(); check_all();
    chk("midrec_ready_back", a_in_ready, 1'b1);
    send_scene(1, 1'b1);
    fire_frame();
    chk("post_reset_wsize", a_wsize, 12'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
